// File: rtl/tanh_pkg.sv
// Shared definitions for the tanh table-interpolation sequencer: default
// widths, derived table constants, FSM state encoding and the sign-safe
// magnitude helper.
package tanh_pkg;

    localparam int TANH_DATA_W = 32;
    localparam int TANH_FRAC_W = 8;
    localparam int TANH_SHIFT  = 6;
    localparam int TANH_ADDR_W = 5;

    // 1.0 in Q.FRAC_W and the number of table entries
    localparam logic [TANH_DATA_W-1:0] ONE = TANH_DATA_W'(1) << TANH_FRAC_W;
    localparam int N = 1 << TANH_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_BASE,
        RD_NEXT,
        CALC,
        OUT
    } state_t;

    // |x| with one extra bit so the most-negative input does not wrap
    function automatic logic [TANH_DATA_W:0] abs_ext(input logic [TANH_DATA_W-1:0] x);
        logic [TANH_DATA_W:0] ext;
        ext = {x[TANH_DATA_W-1], x};
        return x[TANH_DATA_W-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/tanh_lerp.sv
// Combinational linear interpolation between two adjacent table entries:
// lerp = base + ((next - base) * frac) >>> SHIFT, truncated to DATA_W.
module tanh_lerp #(
    parameter int DATA_W = 32,
    parameter int SHIFT  = 6
) (
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] next,
    input  logic [SHIFT-1:0]  frac,
    output logic [DATA_W-1:0] lerp
);

    // Product needs DATA_W+1 bits of signed difference times an unsigned
    // SHIFT-bit fraction (one extra bit for its zero sign).
    localparam int PROD_W = DATA_W + SHIFT + 2;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] prod;

    assign diff     = $signed({next[DATA_W-1], next}) - $signed({base[DATA_W-1], base});
    assign diff_ext = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    assign frac_ext = {{(PROD_W-SHIFT){1'b0}}, frac};
    assign prod     = diff_ext * frac_ext;
    assign lerp     = base + DATA_W'(prod >>> SHIFT);

endmodule

// File: rtl/tanh_lut_sequencer.sv
// Sequencer computing tanh(x) from an external 1-cycle-latency LUT ROM:
// handshakes x in, splits |x| into table index and fraction, reads two
// adjacent entries, interpolates, restores the sign and hands y out.
// Inputs beyond the last interpolation interval saturate to +/-1.0.
module tanh_lut_sequencer
    import tanh_pkg::*;
#(
    parameter int DATA_W = TANH_DATA_W,
    parameter int FRAC_W = TANH_FRAC_W,
    parameter int SHIFT  = TANH_SHIFT,
    parameter int ADDR_W = TANH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [DATA_W-1:0] ONE_Y  = DATA_W'(1) << FRAC_W;
    localparam int                IDX_W  = DATA_W - SHIFT + 1;
    localparam logic [IDX_W-1:0]  SAT_AT = IDX_W'((1 << ADDR_W) - 1);

    state_t state_reg;
    state_t state_next;

    logic              sign_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [SHIFT-1:0]  frac_reg;
    logic [DATA_W-1:0] base_reg;
    logic [DATA_W-1:0] y_reg;

    logic [DATA_W:0]   mag;
    logic [IDX_W-1:0]  idx_full;
    logic              sat;
    logic              accept;
    logic [DATA_W-1:0] lerp;

    assign mag      = abs_ext(in_x);
    assign idx_full = mag[DATA_W:SHIFT];
    // The last interval that has a "next" entry is N-2; beyond that saturate.
    assign sat      = (idx_full >= SAT_AT);
    assign accept   = in_valid && (state_reg == IDLE);

    // Interpolate between the captured base entry and the live next entry.
    tanh_lerp #(
        .DATA_W(DATA_W),
        .SHIFT (SHIFT)
    ) u_lerp (
        .base(base_reg),
        .next(rom_data),
        .frac(frac_reg),
        .lerp(lerp)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = sat ? OUT : RD_BASE;
            RD_BASE: state_next = RD_NEXT;
            RD_NEXT: state_next = CALC;
            CALC:    state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs: handshakes and ROM strobe decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            RD_BASE: begin
                rom_en   = 1'b1;
                rom_addr = idx_reg;
            end
            RD_NEXT: begin
                rom_en   = 1'b1;
                rom_addr = idx_reg + 1'b1;
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_y = y_reg;

    // Datapath: split x on accept, capture base entry, register the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_reg <= 1'b0;
            idx_reg  <= '0;
            frac_reg <= '0;
            base_reg <= '0;
            y_reg    <= '0;
        end else begin
            if (accept) begin
                sign_reg <= in_x[DATA_W-1];
                idx_reg  <= mag[SHIFT +: ADDR_W];
                frac_reg <= mag[SHIFT-1:0];
                if (sat) y_reg <= in_x[DATA_W-1] ? (~ONE_Y + 1'b1) : ONE_Y;
            end
            if (state_reg == RD_NEXT) base_reg <= rom_data;
            if (state_reg == CALC)    y_reg    <= sign_reg ? (~lerp + 1'b1) : lerp;
        end
    end

endmodule

// File: doc/tanh_lut_sequencer.md
Name: tanh_lut_sequencer

Overview:
Controller that turns one signed fixed-point input x into tanh(x) using the table-interpolation datapath. It accepts x on a valid/ready handshake and splits it into table index and fraction. It then fetches the base and next entries from an external 1-cycle-latency LUT ROM, drives the interpolation arithmetic and returns y on a valid/ready handshake. It uses odd symmetry (tanh(-x) = -tanh(x)) and saturates outside the table range. It sits between the neuron accumulator output and the activation result register in the NN datapath.

Parameters:
DATA_W, 32, width of x, y and ROM words (two's complement).
FRAC_W, 8, fractional bits of x and y (Q.FRAC_W); ONE = 1 << FRAC_W.
SHIFT, 6, fraction bits per table step; step = 2^(SHIFT-FRAC_W).
ADDR_W, 5, ROM address width; N = 2^ADDR_W entries; entry k = tanh(k*step) in Q.FRAC_W.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  x presented.
in_ready  output  1  block can accept x.
in_x  input  DATA_W  signed input.
out_valid  output  1  y available.
out_ready  input  1  consumer takes y.
out_y  output  DATA_W  signed tanh result, Q.FRAC_W.
rom_en  output  1  ROM read strobe.
rom_addr  output  ADDR_W  ROM read address.
rom_data  input  DATA_W  ROM word; valid the cycle after rom_en/rom_addr.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state): state = IDLE, in_ready = 1, out_valid = 0, out_y = 0, rom_en = 0, rom_addr = 0, all internal registers = 0.
- Accept: in_valid & in_ready at a rising edge.
  - Register sign = in_x[DATA_W-1].
  - Register mag = |in_x|, computed in DATA_W+1 bits so the most-negative value is safe.
  - Register idx = mag >> SHIFT and frac = mag[SHIFT-1:0].
- in_ready = 1 only in IDLE. There is no overlap between transactions.
- States:
  - IDLE: on accept, if idx >= N-1, register y = sign ? -ONE : ONE and go to OUT. Otherwise go to RD_BASE.
  - RD_BASE: rom_en = 1, rom_addr = idx; go to RD_NEXT.
  - RD_NEXT: rom_en = 1, rom_addr = idx+1; capture base = rom_data at end of cycle; go to CALC.
  - CALC: rom_en = 0; the interpolator uses base and next = rom_data (live this cycle); register y = sign ? -lerp : lerp; go to OUT.
  - OUT: out_valid = 1 and out_y = registered y, held stable until out_ready. On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
- rom_en = 0 in IDLE and OUT.
- Latency from the accept edge to out_valid high:
  - Table path: 4 cycles.
  - Saturated path: 1 cycle.
  - Throughput: one result per 5 cycles when out_ready is held high.
- Arithmetic (tanh_lerp, combinational):
  - diff = next - base, signed DATA_W+1 bits.
  - prod = diff * frac, with frac zero-extended and the product signed.
  - lerp = base + (prod >>> SHIFT), truncated to DATA_W.
  - Negation is two's complement in DATA_W.
- Boundaries:
  - idx = N-2 is the last interpolated index; it reads entry N-1.
  - x = 0 gives y = 0 with sign ignored.
  - Most-negative in_x saturates to -ONE.
  - in_valid outside IDLE is ignored and in_x is not sampled.
  - out_ready while out_valid = 0 has no effect.
- Reset asserted mid-transaction discards it. No ROM strobe or out_valid appears after reset deasserts until a new accept.

Decomposition:
- Package tanh_pkg:
  - state enum {IDLE, RD_BASE, RD_NEXT, CALC, OUT};
  - localparams ONE and N;
  - function abs_ext (DATA_W+1 magnitude).
- Sub-module tanh_lerp: combinational (base, next, frac) -> lerp. It is the shared interpolation datapath, also usable standalone for unit checks.
- The sequencer holds the FSM, handshakes, index/fraction split, sign handling and saturation.

Test Plan:
Common setup: defaults FRAC_W=8, SHIFT=6, ADDR_W=5; ROM model with entry0 = 0, entry1 = 63, entry2 = 118, entry31 = 255, 1-cycle latency.
1. in_x = 0x00000020 (0.125), out_ready = 1 -> rom_addr 0 then 1 on consecutive cycles; out_valid 4 cycles after accept; out_y = 31 (0x1F).
2. in_x = 0xFFFFFFE0 (-0.125) -> out_y = 0xFFFFFFE1 (-31). in_x = 0x00000040 -> idx 1, frac 0, out_y = 63.
3. Saturation:
   - in_x = 0x000007C0 (idx 31) -> no rom_en pulse; out_valid 1 cycle after accept; out_y = 0x100.
   - in_x = 0x80000000 -> out_y = 0xFFFFFF00.
4. Backpressure: out_ready held 0 for 5 cycles in OUT -> out_y and out_valid stable, in_ready = 0, new in_valid ignored. out_ready = 1 -> IDLE next cycle; in_ready = 1.
5. Reset: assert rst during RD_NEXT -> same-cycle async clear: out_valid = 0, rom_en = 0, busy = 0, in_ready = 1. The next transaction (in_x = 0x40) completes with out_y = 63.
6. Back-to-back: 8 random in_x with out_ready = 1 -> each result matches the reference model; accepts spaced exactly 5 cycles apart.
